// File: rtl/apb_slave_regfile_completer_pkg.sv
// Shared APB definitions: FSM state, default bus widths, ID register constants
// and transfer direction encodings common to the bridge and its completers.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [APB_ADDR_W-1:0] APB_ID_ADDR  = 8'h0F;
  localparam logic [APB_DATA_W-1:0] APB_ID_VALUE = 8'hA5;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/apb_slave_regfile_completer_if.sv
// APB requester/completer bus bundle; master drives the transfer, slave answers.
interface apb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile_completer_regfile.sv
// DEPTH x DATA_W register storage: one synchronous write port, one
// combinational read port, every entry cleared by the asynchronous reset.
module apb_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET)                          mem[i] <= '0;
      else if (we && (waddr == AW'(i)))   mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile_completer.sv
// APB completer fronting a small register file: setup/access FSM with
// programmable wait states, address decode, read-only ID register and PSLVERR.
module apb_slave_regfile_completer
  import apb_pkg::*;
#(
  parameter int                ADDR_W   = APB_ADDR_W,
  parameter int                DATA_W   = APB_DATA_W,
  parameter int                DEPTH    = 16,
  parameter logic [ADDR_W-1:0] ID_ADDR  = APB_ID_ADDR,
  parameter logic [DATA_W-1:0] ID_VALUE = APB_ID_VALUE
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic [1:0] wait_cfg,
  apb_if.slave       bus
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  apb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dir_q, dir_d;

  logic              addr_ok;
  logic              is_id;
  logic              pready;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;

  // Decode always works on the latched address; the live bus is ignored in ACCESS.
  assign addr_ok = ({1'b0, addr_q} < DEPTH_LIM);
  assign is_id   = (addr_q == ID_ADDR);
  assign pready  = (state_q == ACCESS) && (cnt_q == 2'd0);

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    rf_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high is not a legal setup phase; drop it.
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d  = bus.PADDR;
          wdata_d = bus.PWDATA;
          dir_d   = bus.PWRITE;
          cnt_d   = wait_cfg;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (bus.PENABLE) begin
          state_d = IDLE;
          rf_we   = (dir_q == WRITE) && addr_ok && !is_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  apb_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_regfile (
    .PCLK  (PCLK),
    .RESET (RESET),
    .we    (rf_we),
    .waddr (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .raddr (addr_q[AW-1:0]),
    .rdata (rf_rdata)
  );

  always_comb begin
    bus.PREADY  = pready;
    bus.PSLVERR = pready && !addr_ok;
    bus.PRDATA  = '0;
    if (pready && (dir_q == READ) && addr_ok)
      bus.PRDATA = is_id ? ID_VALUE : rf_rdata;
  end

endmodule

// File: tb/tb_apb_slave_regfile_completer.sv
// Directed bench: the driver pushes the expected response for each transfer,
// a negedge monitor pops and compares whenever the completer raises PREADY.
module tb_apb_slave_regfile_completer;

  logic       PCLK = 1'b0;
  logic       RESET;
  logic [1:0] wait_cfg;

  apb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_slave_regfile_completer dut (
    .PCLK     (PCLK),
    .RESET    (RESET),
    .wait_cfg (wait_cfg),
    .bus      (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         waits;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   wcnt  = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Monitor: every ACCESS cycle is checked; completions pop the scoreboard.
  always @(negedge PCLK) begin
    exp_t e;
    if (RESET) begin
      wcnt = 0;
    end else if (bus.PREADY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_pready act=1 exp=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("prdata",  32'(bus.PRDATA),  32'(e.rdata));
        chk("pslverr", 32'(bus.PSLVERR), 32'(e.err));
        chk("waits",   32'(wcnt),        32'(e.waits));
      end
      wcnt = 0;
    end else if (bus.PSEL && bus.PENABLE) begin
      wcnt++;
      chk("wait_prdata",  32'(bus.PRDATA),  32'h0);
      chk("wait_pslverr", 32'(bus.PSLVERR), 32'h0);
    end else begin
      wcnt = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion edge, with the
  // bus idle, so a following call issues its setup phase back-to-back.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [1:0] wc, input logic [7:0] er, input logic ee);
    exp_t e;
    bit   done;
    e.rdata = er;
    e.err   = ee;
    e.waits = int'(wc);
    sb.push_back(e);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    wait_cfg    = wc;
    @(posedge PCLK); #1;
    // Scramble everything but the handshake: the completer must use latched values.
    bus.PENABLE = 1'b1;
    bus.PWRITE  = ~wr;
    bus.PADDR   = ~a;
    bus.PWDATA  = ~d;
    wait_cfg    = ~wc;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge PCLK);
      if (bus.PREADY) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout addr=%0h act=no_pready exp=pready", a);
      e = sb.pop_back();
    end
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    RESET       = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    wait_cfg    = 2'd0;
    repeat (2) @(negedge PCLK);
    chk("rst_pready",  32'(bus.PREADY),  32'h0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("rst_prdata",  32'(bus.PRDATA),  32'h0);
    @(posedge PCLK); #1;
    RESET = 1'b0;
    idle(1);

    // Basic write/read, zero and two wait states
    xfer(1'b1, 8'h02, 8'h3C, 2'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 2'd0, 8'h3C, 1'b0);
    idle(1);
    xfer(1'b0, 8'h02, 8'h00, 2'd2, 8'h3C, 1'b0);
    idle(1);

    // Out-of-range addresses, including the first one past the file
    xfer(1'b1, 8'h20, 8'h55, 2'd0, 8'h00, 1'b1);
    xfer(1'b0, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h20, 8'h00, 2'd0, 8'h00, 1'b1);
    xfer(1'b1, 8'h10, 8'hEE, 2'd1, 8'h00, 1'b1);
    xfer(1'b0, 8'h10, 8'h00, 2'd0, 8'h00, 1'b1);
    idle(2);

    // ID register is read-only and never errors
    xfer(1'b1, 8'h0F, 8'hFF, 2'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h0F, 8'h00, 2'd0, 8'hA5, 1'b0);
    xfer(1'b1, 8'h0E, 8'hC3, 2'd1, 8'h00, 1'b0);
    xfer(1'b0, 8'h0E, 8'h00, 2'd3, 8'hC3, 1'b0);
    idle(1);

    // Back-to-back, no idle cycles in between
    xfer(1'b1, 8'h01, 8'h11, 2'd0, 8'h00, 1'b0);
    xfer(1'b1, 8'h03, 8'h33, 2'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h01, 8'h00, 2'd0, 8'h11, 1'b0);
    xfer(1'b0, 8'h03, 8'h00, 2'd1, 8'h33, 1'b0);
    idle(1);

    // Abort by dropping PSEL mid-ACCESS
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h04; bus.PWDATA = 8'h77; wait_cfg = 2'd3;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_wait_pready", 32'(bus.PREADY), 32'h0);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("abort_idle_pready", 32'(bus.PREADY), 32'h0);
    @(posedge PCLK); #1;
    xfer(1'b0, 8'h04, 8'h00, 2'd0, 8'h00, 1'b0);
    idle(1);

    // Abort by reset mid-ACCESS; reset also clears the file
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h04; bus.PWDATA = 8'h77; wait_cfg = 2'd3;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    RESET = 1'b1;
    #1;
    chk("rstabort_pready", 32'(bus.PREADY), 32'h0);
    chk("rstabort_prdata", 32'(bus.PRDATA), 32'h0);
    @(posedge PCLK); #1;
    RESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    idle(1);
    xfer(1'b0, 8'h04, 8'h00, 2'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 2'd0, 8'h00, 1'b0);
    idle(2);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left act=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
